fetch_unit: RTL

Instruction-fetch stage for the WISC-SP13 multi-cycle core. It is the producer side of the decode interface: it owns the PC, requests instruction words from a stallable instruction memory, and presents instr/pc2 to decode under a valid/ack handshake. It consumes decode's redirect controls (brj, pcregsel, fimm, register, halt) to form the next PC, and it latches halt and error conditions.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_nextpc.sv | 32 +++
 rtl/fetch_unit.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared types and opcode constants for the instruction-fetch stage
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam word_t c_nop_instr  = 16'h0800;
    localparam word_t c_halt_instr = 16'h0000;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_nextpc.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_nextpc
// Purpose  : Next-PC adder/mux for branch and jump redirects, plus misalign flag
// Revision : 1.0 - initial release
// ============================================================================
module fetch_nextpc
    import fetch_pkg::*;
(
    input  logic  brj,
    input  logic  pcregsel,
    input  word_t fimm,
    input  word_t register,
    input  word_t pc2,
    output word_t next_pc,
    output logic  misalign
);

    word_t w_base;
    word_t w_target;

    // Carries out of bit 15 are dropped so targets wrap around the address space
    always_comb begin
        w_base   = pcregsel ? register : pc2;
        w_target = w_base + fimm;
        next_pc  = brj ? w_target : pc2;
        misalign = next_pc[0];
    end

endmodule : fetch_nextpc
`default_nettype wire

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Fetch stage: owns the PC, reads a stallable imem, hands words to decode
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter word_t RESET_PC  = 16'h0000,
    parameter word_t NOP_INSTR = c_nop_instr
) (
    input  logic  clk,
    input  logic  rst,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_rdy,
    input  word_t imem_data,
    input  logic  imem_err,
    output word_t instr,
    output word_t pc2,
    output logic  instr_vld,
    input  logic  instr_ack,
    input  logic  brj,
    input  logic  pcregsel,
    input  word_t fimm,
    input  word_t register,
    input  logic  halt,
    output logic  halted,
    output logic  err
);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_req;
    word_t  r_pc;
    word_t  r_pc2;
    word_t  r_instr;
    logic   r_halted;
    logic   r_err;

    logic   w_capture;
    logic   w_fault;
    logic   w_take_halt;
    logic   w_advance;
    word_t  w_next_pc;
    logic   w_misalign;

    fetch_nextpc u_nextpc (
        .brj      (brj),
        .pcregsel (pcregsel),
        .fimm     (fimm),
        .register (register),
        .pc2      (r_pc2),
        .next_pc  (w_next_pc),
        .misalign (w_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FETCH is entered with the request still low right after reset; the
    // registered request then rises and the state waits for it before sampling rdy.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_fault     = 1'b0;
        w_take_halt = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            FETCH, WAIT: begin
                if (r_req) begin
                    if (imem_rdy) begin
                        if (imem_err) begin
                            w_fault     = 1'b1;
                            w_state_nxt = HALTED;
                        end else begin
                            w_capture   = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            HOLD: begin
                if (instr_ack) begin
                    if (halt) begin
                        w_take_halt = 1'b1;
                        w_state_nxt = HALTED;
                    end else if (w_misalign) begin
                        w_fault     = 1'b1;
                        w_state_nxt = HALTED;
                    end else begin
                        w_advance   = 1'b1;
                        w_state_nxt = FETCH;
                    end
                end
            end
            default: w_state_nxt = HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req    <= 1'b0;
            r_pc     <= RESET_PC;
            r_pc2    <= RESET_PC;
            r_instr  <= NOP_INSTR;
            r_halted <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_req <= (w_state_nxt == FETCH) || (w_state_nxt == WAIT);
            if (w_capture) begin
                r_instr <= imem_data;
                r_pc2   <= r_pc + 16'd2;
            end
            if (w_fault) begin
                r_err <= 1'b1;
            end
            if (w_take_halt) begin
                r_halted <= 1'b1;
            end
            if (w_advance) begin
                r_pc <= w_next_pc;
            end
        end
    end

    always_comb begin
        imem_req  = r_req;
        imem_addr = r_pc;
        instr_vld = (r_state == HOLD);
        instr     = (r_state == HOLD) ? r_instr : NOP_INSTR;
        pc2       = r_pc2;
        halted    = r_halted;
        err       = r_err;
    end

endmodule : fetch_unit
`default_nettype wire
